// File: rtl/bias_bank_loader_pkg.sv
// Shared types and constants for the bias bank loader and its packer.
package bias_bank_loader_pkg;

  localparam int BIAS_W  = 18;
  localparam int N_BANKS = 8;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bank index; same encoding as the selector's z input (0 selects BIAS_1).
  typedef logic [2:0] bank_idx_t;

  localparam bank_idx_t LAST_BANK = bank_idx_t'(N_BANKS - 1);

  // Advance to the next bank, wrapping 7 -> 0.
  function automatic bank_idx_t next_bank(input bank_idx_t b);
    return b + bank_idx_t'(1);
  endfunction

endpackage

// File: rtl/bias_bank_loader_if.sv
// Word-stream handshake between the weight/bias memory reader and the loader.
interface bias_bank_loader_if;
  import bias_bank_loader_pkg::*;

  logic              start;
  logic [BIAS_W-1:0] bias_in;
  logic              bias_valid;
  logic              bias_ready;

  // The reader drives words and the start pulse.
  modport master (
    output start,
    output bias_in,
    output bias_valid,
    input  bias_ready
  );

  // The loader consumes words and reports readiness.
  modport slave (
    input  start,
    input  bias_in,
    input  bias_valid,
    output bias_ready
  );

endinterface

// File: rtl/bias_bank_loader_packer.sv
// Collects consecutive bias words into one bank-wide vector. The final word
// of a bank is not stored: it is concatenated straight from the input so the
// bank can be committed on the same edge it arrives.
module bias_word_packer
  import bias_bank_loader_pkg::*;
#(
  parameter int N_adder_tree = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           accept,
  input  logic [BIAS_W-1:0]              bias_in,
  output logic [N_adder_tree*BIAS_W-1:0] packed_bank,
  output logic                           bank_complete
);

  generate
    if (N_adder_tree == 1) begin : g_single
      // Every accepted word is a full bank on its own.
      assign packed_bank   = bias_in;
      assign bank_complete = accept;
    end else begin : g_multi
      localparam int CNT_W = $clog2(N_adder_tree);
      localparam int STG_W = (N_adder_tree - 1) * BIAS_W;

      logic [CNT_W-1:0] word_cnt;
      logic [STG_W-1:0] staging;
      logic             last_word;

      assign last_word     = (word_cnt == CNT_W'(N_adder_tree - 1));
      assign bank_complete = accept && last_word;
      assign packed_bank   = {bias_in, staging};

      // Word counter and staging lanes; first accepted word lands in lane 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_cnt <= '0;
          staging  <= '0;
        end else if (clear) begin
          word_cnt <= '0;
          staging  <= '0;
        end else if (accept) begin
          if (last_word) begin
            word_cnt <= '0;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            for (int k = 0; k < N_adder_tree - 1; k++) begin
              if (word_cnt == CNT_W'(k)) begin
                staging[k*BIAS_W +: BIAS_W] <= bias_in;
              end
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/bias_bank_loader.sv
// Bias bank loader: fills the eight bias banks read by the 8:1 bias selector
// from a serial stream of 18-bit words. Banks are committed whole, so the
// selector never sees a partially written bank.
module bias_bank_loader
  import bias_bank_loader_pkg::*;
#(
  parameter int N_adder_tree = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  bias_bank_loader_if.slave              bus,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_1,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_2,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_3,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_4,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_5,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_6,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_7,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_8,
  output logic [N_BANKS-1:0]             bank_valid,
  output logic                           load_done
);

  localparam int BANK_W = N_adder_tree * BIAS_W;

  state_t            state;
  bank_idx_t         bank_cnt;
  logic [BANK_W-1:0] bank_q [N_BANKS];
  logic [BANK_W-1:0] packed_bank;
  logic              bank_complete;
  logic              accept;

  // A start pulse always wins over a word in the same cycle.
  assign bus.bias_ready = (state == LOAD) && !bus.start;
  assign accept         = bus.bias_valid && bus.bias_ready;

  bias_word_packer #(
    .N_adder_tree (N_adder_tree)
  ) u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (bus.start),
    .accept        (accept),
    .bias_in       (bus.bias_in),
    .packed_bank   (packed_bank),
    .bank_complete (bank_complete)
  );

  // Sequencing FSM, bank counter and bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bank_cnt   <= '0;
      bank_valid <= '0;
      load_done  <= 1'b0;
      for (int b = 0; b < N_BANKS; b++) begin
        bank_q[b] <= '0;
      end
    end else if (bus.start) begin
      // Restart from bank 1; previously loaded banks stay until overwritten.
      state      <= LOAD;
      bank_cnt   <= '0;
      bank_valid <= '0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bank_complete) begin
            bank_q[bank_cnt]     <= packed_bank;
            bank_valid[bank_cnt] <= 1'b1;
            bank_cnt             <= next_bank(bank_cnt);
            if (bank_cnt == LAST_BANK) begin
              load_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        IDLE:    state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BIAS_1 = bank_q[0];
  assign BIAS_2 = bank_q[1];
  assign BIAS_3 = bank_q[2];
  assign BIAS_4 = bank_q[3];
  assign BIAS_5 = bank_q[4];
  assign BIAS_6 = bank_q[5];
  assign BIAS_7 = bank_q[6];
  assign BIAS_8 = bank_q[7];

endmodule

// File: tb/tb_bias_bank_loader.sv
// Self-checking bench for bias_bank_loader with two lanes per bank.
module tb_bias_bank_loader;
  import bias_bank_loader_pkg::*;

  localparam int N      = 2;
  localparam int BANK_W = N * BIAS_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [BANK_W-1:0] bias_o [8];
  logic [7:0]        bank_valid;
  logic              load_done;

  int n_cmp = 0;
  int n_mis = 0;

  bias_bank_loader_if bus ();

  bias_bank_loader #(.N_adder_tree(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .BIAS_1     (bias_o[0]),
    .BIAS_2     (bias_o[1]),
    .BIAS_3     (bias_o[2]),
    .BIAS_4     (bias_o[3]),
    .BIAS_5     (bias_o[4]),
    .BIAS_6     (bias_o[5]),
    .BIAS_7     (bias_o[6]),
    .BIAS_8     (bias_o[7]),
    .bank_valid (bank_valid),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue per bank, committed whole when N words are in.
  logic [BIAS_W-1:0] q_m [$];
  logic [BANK_W-1:0] bank_m [8];
  int                idx_m     = 0;
  logic [7:0]        valid_m   = '0;
  logic              done_m    = 1'b0;
  bit                loading_m = 1'b0;

  initial for (int b = 0; b < 8; b++) bank_m[b] = '0;

  always @(posedge clk or posedge rst) begin
    logic [BANK_W-1:0] v;
    if (rst) begin
      q_m.delete();
      for (int b = 0; b < 8; b++) bank_m[b] = '0;
      idx_m = 0; valid_m = '0; done_m = 1'b0; loading_m = 1'b0;
    end else if (bus.start) begin
      q_m.delete();
      idx_m = 0; valid_m = '0; done_m = 1'b0; loading_m = 1'b1;
    end else if (loading_m && bus.bias_valid) begin
      q_m.push_back(bus.bias_in);
      if (q_m.size() == N) begin
        v = '0;
        for (int k = 0; k < N; k++) v[k*BIAS_W +: BIAS_W] = q_m[k];
        bank_m[idx_m] = v;
        valid_m[idx_m] = 1'b1;
        idx_m++;
        q_m.delete();
        if (idx_m == 8) begin
          done_m = 1'b1; loading_m = 1'b0; idx_m = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    for (int b = 0; b < 8; b++) check($sformatf("model_bias%0d", b + 1), 64'(bias_o[b]), 64'(bank_m[b]));
    check("model_bank_valid", 64'(bank_valid), 64'(valid_m));
    check("model_load_done", 64'(load_done), 64'(done_m));
    check("model_bias_ready", 64'(bus.bias_ready), 64'(loading_m && !bus.start));
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic cycle(input logic st, input logic vld, input logic [BIAS_W-1:0] d);
    bus.start = st; bus.bias_valid = vld; bus.bias_in = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [BIAS_W-1:0] w;
    bus.start = 1'b0; bus.bias_valid = 1'b0; bus.bias_in = '0;

    // Reset then idle with valid asserted but no start.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 18'(i + 5));
    check("idle_bias1", 64'(bias_o[0]), 64'd0);
    check("idle_ready", 64'(bus.bias_ready), 64'd0);
    check("idle_valid", 64'(bank_valid), 64'd0);
    check("idle_done", 64'(load_done), 64'd0);

    // Full back-to-back load of words 1..16.
    cycle(1'b1, 1'b0, '0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 18'(i));
      if (i % 2 == 0) check("full_bank_valid_step", 64'(bank_valid), 64'((1 << (i / 2)) - 1));
      if (i == 15) check("full_no_done_early", 64'(load_done), 64'd0);
    end
    check("full_bias1", 64'(bias_o[0]), 64'({18'h00002, 18'h00001}));
    check("full_bias8", 64'(bias_o[7]), 64'({18'h00010, 18'h0000F}));
    check("full_valid_ff", 64'(bank_valid), 64'hFF);
    check("full_done", 64'(load_done), 64'd1);
    check("full_ready_after", 64'(bus.bias_ready), 64'd0);
    cycle(1'b0, 1'b1, 18'h3ABCD);
    check("done_ignores_word", 64'(bias_o[0]), 64'({18'h00002, 18'h00001}));

    // Stalled stream from a clean reset.
    do_reset();
    cycle(1'b1, 1'b0, '0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 18'(i));
      if (i == 1) check("stall_bias1_hold", 64'(bias_o[0]), 64'd0);
      if (i == 2) check("stall_bias1_commit", 64'(bias_o[0]), 64'({18'h00002, 18'h00001}));
      cycle(1'b0, 1'b0, 18'h2DEAD);
    end
    check("stall_bias8", 64'(bias_o[7]), 64'({18'h00010, 18'h0000F}));
    check("stall_done", 64'(load_done), 64'd1);

    // Restart mid-bank.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 18'h3FFFF);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 18'h12345);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 18'h00AAA);
    cycle(1'b0, 1'b1, 18'h00BBB);
    check("restart_bias1", 64'(bias_o[0]), 64'({18'h00BBB, 18'h00AAA}));
    check("restart_bias2", 64'(bias_o[1]), 64'({18'h3FFFF, 18'h3FFFF}));
    check("restart_bias8", 64'(bias_o[7]), 64'({18'h3FFFF, 18'h3FFFF}));
    check("restart_valid", 64'(bank_valid), 64'h01);

    // start with a word in the same cycle: the word is dropped.
    cycle(1'b1, 1'b1, 18'h11111);
    cycle(1'b0, 1'b1, 18'h22222);
    cycle(1'b0, 1'b1, 18'h33333);
    check("startword_bias1", 64'(bias_o[0]), 64'({18'h33333, 18'h22222}));

    // Async reset between edges after five words.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 18'(i + 100));
    #2 rst = 1'b1;
    #1;
    check("async_bias1", 64'(bias_o[0]), 64'd0);
    check("async_bias2", 64'(bias_o[1]), 64'd0);
    check("async_valid", 64'(bank_valid), 64'd0);
    check("async_ready", 64'(bus.bias_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 18'h0A0A0);
    cycle(1'b0, 1'b1, 18'h0B0B0);
    check("async_resume_bias1", 64'(bias_o[0]), 64'({18'h0B0B0, 18'h0A0A0}));
    check("async_resume_bias2", 64'(bias_o[1]), 64'd0);

    // Randomized traffic against the model, with sporadic starts and resets.
    for (int i = 0; i < 1500; i++) begin
      w = 18'($urandom);
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), w);
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end

    cycle(1'b0, 1'b0, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bias_bank_loader.md
Name: bias_bank_loader

Overview:
- Writer-side counterpart of the 8:1 bias selector: fills the eight bias banks BIAS_1..BIAS_8 that the selector reads.
- Accepts a serial stream of 18-bit bias words over a valid/ready handshake.
- Packs N_adder_tree words per bank and commits each bank as a whole, banks 1..8 in order.
- Sits between the weight/bias memory reader and the layer's bias selector.

Parameters:
- N_adder_tree, 16, number of 18-bit bias lanes per bank (bank width = N_adder_tree*18).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a full 8-bank load.
- bias_in  input  18  signed bias word.
- bias_valid  input  1  bias_in is valid this cycle.
- bias_ready  output  1  loader accepts a word this cycle.
- BIAS_1 .. BIAS_8  output  N_adder_tree*18 each  registered bias banks.
- bank_valid  output  8  bit b set once bank b+1 has been committed since the last start.
- load_done  output  1  all 8 banks committed; held until next start or reset.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; word_cnt=0; bank_cnt=0; staging=0.
  - All BIAS_n=0; bank_valid=0; load_done=0; bias_ready=0.
- States and transitions:
  - IDLE: waiting for start.
  - LOAD: collecting words.
  - DONE: full set loaded.
  - IDLE -start-> LOAD.
  - LOAD -accept of last word of bank 8-> DONE.
  - DONE -start-> LOAD.
  - start in LOAD restarts the load.
- Handshake:
  - bias_ready = (state==LOAD) && !start (combinational from state and start).
  - A word is accepted on a rising edge where bias_valid && bias_ready.
  - bias_valid without ready: word ignored, no state change.
- Packing:
  - Word k (k=0..N_adder_tree-1) of a bank occupies bits [k*18 +: 18]; the first accepted word is the LSB lane.
  - Words 0..N_adder_tree-2 go into the staging register.
  - On the accepting edge of word N_adder_tree-1:
    - BIAS_(bank_cnt+1) <= {bias_in, staging[N_adder_tree*18-19:0]};
    - bank_valid[bank_cnt] <= 1; word_cnt <= 0; bank_cnt <= bank_cnt+1 (3-bit wrap).
  - The bank is visible the cycle after that edge. A bank never shows a partially written value.
- Completion:
  - The edge that commits bank 8 (bank_cnt==7) also sets load_done=1 and moves the state to DONE.
  - bank_cnt wraps to 0.
- start (any state, including mid-bank in LOAD):
  - word_cnt=0, bank_cnt=0, staging=0, bank_valid=0, load_done=0, state=LOAD.
  - BIAS_n keep their old values until overwritten.
  - A word presented in the start cycle is not accepted (ready=0).
- No bias_valid in IDLE/DONE has any effect.
- Bias words are passed bit-exact: no sign extension or arithmetic.
- Reset mid-load: immediate return to the reset values above; partial staging is discarded.
- N_adder_tree=1: every accepted word commits a bank directly; staging is unused.

Decomposition:
- Shared package:
  - BIAS_W=18, N_BANKS=8;
  - state enum {IDLE, LOAD, DONE};
  - the 3-bit bank index type (the same encoding the selector's z uses: 0 selects BIAS_1).
- One natural sub-module, bias_word_packer:
  - owns the staging register and word counter;
  - outputs the packed bank vector and a bank_complete strobe.
- The top level holds the FSM, bank counter and the 8 bank registers.

Test Plan (N_adder_tree=2 unless noted):
- Reset then idle: rst pulse, bias_valid=1 with no start -> all BIAS_n=0, bias_ready=0, bank_valid=0, load_done=0.
- Full load:
  - Stimulus: start, then 16 back-to-back words 0x00001..0x00010.
  - BIAS_1=0x00002_00001 (concatenated lanes).
  - BIAS_8=0x00010_0000F.
  - bank_valid steps 0x01, 0x03, ..., 0xFF.
  - load_done=1 on the cycle after word 16; bias_ready=0 afterwards.
- Stalls: same stream with bias_valid toggled 1/0 each cycle -> identical final banks; BIAS_1 updates only after its 2nd accepted word.
- Restart mid-bank:
  - Stimulus: full load of 0x3FFFF, then start, then one word 0x12345, then start again, then words 0x00AAA, 0x00BBB.
  - BIAS_1=0x00BBB_00AAA; BIAS_2..8 still hold 0x3FFFF lanes; bank_valid=0x01.
- start and bias_valid in the same cycle -> word dropped, word_cnt=0; the next valid word lands in lane 0 of BIAS_1.
- Async reset mid-load:
  - Stimulus: rst asserted between clock edges after 5 words.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release + start, loading resumes from BIAS_1 lane 0.
